// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: ALU field encodings, instruction formats,
// major opcodes and the decoded-instruction record held in the stage's storage.
package decode_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    NORMAL = 7'b0000000,
    ALT    = 7'b0100000
  } alu_funct7_e;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SLL  = 3'b001,
    SLT  = 3'b010,
    SLTU = 3'b011,
    XOR  = 3'b100,
    SR   = 3'b101,
    OR   = 3'b110,
    AND  = 3'b111
  } alu_funct3_e;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    INVALID_TYPE
  } inst_format_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    inst_format_e    format;
    logic [6:0]      opcode;
    alu_funct3_e     funct3;
    alu_funct7_e     funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            illegal;
  } decoded_inst_t;

  localparam decoded_inst_t DECODED_RESET = '{
    pc: '0, format: INVALID_TYPE, opcode: '0, funct3: ADD, funct7: NORMAL,
    rs1: '0, rs2: '0, rd: '0, imm: '0, illegal: 1'b0
  };

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate builder: picks and sign-extends the immediate
// bits for the given instruction format; R and INVALID yield zero.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:7]  inst_i,
  input  inst_format_e format_i,
  output logic [31:0]  imm_o
);

  always_comb begin
    imm_o = '0;
    case (format_i)
      I_TYPE:  imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      S_TYPE:  imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      B_TYPE:  imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      U_TYPE:  imm_o = {inst_i[31:12], 12'b0};
      J_TYPE:  imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RISC-V instruction decode stage with valid/ready handshakes and flush.
// Define DECODE_SKID_EN for a two-entry build with a registered in_ready_o.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output inst_format_e    out_format_o,
  output logic [6:0]      out_opcode_o,
  output alu_funct3_e     out_funct3_o,
  output alu_funct7_e     out_funct7_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [4:0]      out_rd_o,
  output logic [31:0]     out_imm_o,
  output logic            out_illegal_o
);

  logic [6:0]    f7;
  logic [2:0]    f3;
  logic          f7_ok;
  inst_format_e  fmt;
  alu_funct7_e   funct7;
  logic [4:0]    rs1, rs2, rd;
  logic          illegal;
  logic [31:0]   imm;
  decoded_inst_t dec;

  assign f7    = in_inst_i[31:25];
  assign f3    = in_inst_i[14:12];
  assign f7_ok = (f7 == NORMAL) || (f7 == ALT);

  always_comb begin
    fmt     = INVALID_TYPE;
    funct7  = NORMAL;
    rs1     = in_inst_i[19:15];
    rs2     = in_inst_i[24:20];
    rd      = in_inst_i[11:7];
    illegal = 1'b0;
    case (opcode_e'(in_inst_i[6:0]))
      OPC_OP: begin
        fmt     = R_TYPE;
        funct7  = alu_funct7_e'(f7);
        illegal = !f7_ok;
      end
      OPC_OP_IMM: begin
        fmt = I_TYPE;
        rs2 = '0;
        // Shift-immediates reuse funct7 as the shift-kind selector.
        if (f3 == SLL || f3 == SR) begin
          funct7  = alu_funct7_e'(f7);
          illegal = !f7_ok || (f3 == SLL && f7 == ALT);
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt = I_TYPE;
        rs2 = '0;
      end
      OPC_STORE: begin
        fmt = S_TYPE;
        rd  = '0;
      end
      OPC_BRANCH: begin
        fmt = B_TYPE;
        rd  = '0;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = U_TYPE;
        rs1 = '0;
        rs2 = '0;
      end
      OPC_JAL: begin
        fmt = J_TYPE;
        rs1 = '0;
        rs2 = '0;
      end
      default: illegal = 1'b1;
    endcase
  end

  decode_stage_imm_gen u_imm_gen (
    .inst_i   (in_inst_i[31:7]),
    .format_i (fmt),
    .imm_o    (imm)
  );

  assign dec = '{
    pc: in_pc_i, format: fmt, opcode: in_inst_i[6:0], funct3: alu_funct3_e'(f3),
    funct7: funct7, rs1: rs1, rs2: rs2, rd: rd, imm: imm, illegal: illegal
  };

  decoded_inst_t out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          accept;

`ifdef DECODE_SKID_EN
  decoded_inst_t skid_q, skid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          drain;

  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && !skid_valid_q && !flush_i;
  assign drain      = out_valid_q && out_ready_i;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      // Output slot frees up: the older skid entry always moves first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_q       <= DECODED_RESET;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= DECODED_RESET;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_pc_o      = out_q.pc;
  assign out_format_o  = out_q.format;
  assign out_opcode_o  = out_q.opcode;
  assign out_funct3_o  = out_q.funct3;
  assign out_funct7_o  = out_q.funct7;
  assign out_rs1_o     = out_q.rs1;
  assign out_rs2_o     = out_q.rs2;
  assign out_rd_o      = out_q.rd;
  assign out_imm_o     = out_q.imm;
  assign out_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage with a queue-based reference
// model plus directed decode, backpressure, flush and reset scenarios.
module tb_decode_stage;
  import decode_stage_pkg::*;

`ifdef DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_i, flush_i, in_valid_i, out_ready_i;
  logic [31:0]     in_inst_i;
  logic [XLEN-1:0] in_pc_i;
  logic            in_ready_o, out_valid_o, out_illegal_o;
  logic [XLEN-1:0] out_pc_o;
  inst_format_e    out_format_o;
  logic [6:0]      out_opcode_o;
  alu_funct3_e     out_funct3_o;
  alu_funct7_e     out_funct7_o;
  logic [4:0]      out_rs1_o, out_rs2_o, out_rd_o;
  logic [31:0]     out_imm_o;

  decode_stage dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_format_o(out_format_o), .out_opcode_o(out_opcode_o),
    .out_funct3_o(out_funct3_o), .out_funct7_o(out_funct7_o),
    .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rd_o(out_rd_o),
    .out_imm_o(out_imm_o), .out_illegal_o(out_illegal_o)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  bit            chk_en = 1'b0;
  decoded_inst_t q[$];
  decoded_inst_t dut_entry;

  assign dut_entry = '{
    pc: out_pc_o, format: out_format_o, opcode: out_opcode_o, funct3: out_funct3_o,
    funct7: out_funct7_o, rs1: out_rs1_o, rs2: out_rs2_o, rd: out_rd_o,
    imm: out_imm_o, illegal: out_illegal_o
  };

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decoder written straight from the RV32I encoding tables.
  function automatic decoded_inst_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    decoded_inst_t d;
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    bit f7_std = (f7 == 7'h00) || (f7 == 7'h20);
    d = '{pc: pc, format: INVALID_TYPE, opcode: i[6:0], funct3: alu_funct3_e'(f3),
          funct7: NORMAL, rs1: i[19:15], rs2: i[24:20], rd: i[11:7], imm: 32'd0,
          illegal: 1'b0};
    case (i[6:0])
      7'h33: begin
        d.format = R_TYPE; d.funct7 = alu_funct7_e'(f7); d.illegal = !f7_std;
      end
      7'h13, 7'h03, 7'h67, 7'h73: begin
        d.format = I_TYPE; d.rs2 = 0;
        d.imm = 32'($signed(i[31:20]));
        if (i[6:0] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          d.funct7  = alu_funct7_e'(f7);
          d.illegal = !f7_std || (f3 == 3'd1 && f7 == 7'h20);
        end
      end
      7'h23: begin
        d.format = S_TYPE; d.rd = 0;
        d.imm = 32'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        d.format = B_TYPE; d.rd = 0;
        d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        d.format = U_TYPE; d.rs1 = 0; d.rs2 = 0;
        d.imm = i[31:12] * 32'd4096;
      end
      7'h6F: begin
        d.format = J_TYPE; d.rs1 = 0; d.rs2 = 0;
        d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic bit m_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready_i;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 11);
    case (k)
      0: i[6:0] = 7'h33;  1: i[6:0] = 7'h13;  2: i[6:0] = 7'h03;
      3: i[6:0] = 7'h67;  4: i[6:0] = 7'h73;  5: i[6:0] = 7'h23;
      6: i[6:0] = 7'h63;  7: i[6:0] = 7'h37;  8: i[6:0] = 7'h17;
      9: i[6:0] = 7'h6F;  default: ;
    endcase
    if ($urandom_range(0, 1) == 1) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return i;
  endfunction

  // Model: FIFO of held decoded instructions, updated on each clock edge.
  always @(posedge clk or posedge rst_i) begin : model
    bit rdy;
    if (rst_i) begin
      q.delete();
    end else begin
      rdy = m_ready();
      if (flush_i) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready_i) void'(q.pop_front());
        if (in_valid_i && rdy) q.push_back(ref_dec(in_inst_i, in_pc_i));
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en && !rst_i) begin
      chk("in_ready", in_ready_o, m_ready());
      chk("out_valid", out_valid_o, q.size() > 0);
      if (q.size() > 0) chk("out_entry", dut_entry, q[0]);
    end
  end

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    @(negedge clk);
    in_valid_i = v; in_inst_i = inst; in_pc_i = pc; out_ready_i = ordy; flush_i = fl;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, out_valid_o, 1'b0);
    chk({tag, "_illegal"}, out_illegal_o, 1'b0);
    chk({tag, "_format"}, out_format_o, INVALID_TYPE);
    chk({tag, "_funct7"}, out_funct7_o, NORMAL);
    chk({tag, "_pc"}, out_pc_o, 32'h0);
    chk({tag, "_imm"}, out_imm_o, 32'h0);
    chk({tag, "_regs"}, {out_rs1_o, out_rs2_o, out_rd_o}, 15'h0);
  endtask

  logic [31:0] got[$];
  logic [31:0] exp_pcs[$];
  bit          c_acc;
  int          leak;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0; in_pc_i = '0;
    out_ready_i = 1'b0;
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready_o, 1'b1);

    // Directed decode with literal expectations
    drive(1, 32'h002081B3, 32'h100, 1, 0); after_edge();
    chk("add_valid", out_valid_o, 1'b1);
    chk("add_fmt", out_format_o, R_TYPE);
    chk("add_regs", {out_rs1_o, out_rs2_o, out_rd_o}, {5'd1, 5'd2, 5'd3});
    chk("add_f3f7", {out_funct3_o, out_funct7_o}, {ADD, NORMAL});
    chk("add_imm", out_imm_o, 32'h0);
    chk("add_pc", out_pc_o, 32'h100);
    chk("add_illegal", out_illegal_o, 1'b0);
    drive(1, 32'h407302B3, 32'h104, 1, 0); after_edge();
    chk("sub_f7", out_funct7_o, ALT);
    chk("sub_regs", {out_rs1_o, out_rs2_o, out_rd_o}, {5'd6, 5'd7, 5'd5});
    drive(1, 32'hFFF00093, 32'h108, 1, 0); after_edge();
    chk("addi_fmt", out_format_o, I_TYPE);
    chk("addi_imm", out_imm_o, 32'hFFFFFFFF);
    chk("addi_rs2", out_rs2_o, 5'd0);
    drive(1, 32'hFE208EE3, 32'h10C, 1, 0); after_edge();
    chk("beq_fmt", out_format_o, B_TYPE);
    chk("beq_imm", out_imm_o, 32'hFFFFFFFC);
    chk("beq_rd", out_rd_o, 5'd0);
    drive(1, 32'h00000000, 32'h110, 1, 0); after_edge();
    chk("zero_fmt", out_format_o, INVALID_TYPE);
    chk("zero_illegal", out_illegal_o, 1'b1);
    drive(0, 32'h0, 32'h0, 1, 0); after_edge();
    chk("idle_valid", out_valid_o, 1'b0);

    // Backpressure: three stalled cycles with A,B,C presented back to back
    drive(1, 32'h00100093, 32'h200, 0, 0);
    drive(1, 32'h00200113, 32'h204, 0, 0);
    drive(1, 32'h00300193, 32'h208, 0, 0);
    #1;
    chk("bp_in_ready_stalled", in_ready_o, 1'b0);
    c_acc = 1'b0;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready_i = 1'b1; in_valid_i = !c_acc; flush_i = 1'b0;
      in_inst_i = 32'h00300193; in_pc_i = 32'h208;
      #1;
      if (out_valid_o) got.push_back(out_pc_o);
      if (in_valid_i && in_ready_o) c_acc = 1'b1;
    end
`ifdef DECODE_SKID_EN
    exp_pcs = '{32'h200, 32'h204, 32'h208};
`else
    exp_pcs = '{32'h200, 32'h208};
`endif
    chk("bp_count", got.size(), exp_pcs.size());
    for (int k = 0; k < exp_pcs.size(); k++)
      if (k < got.size()) chk("bp_order", got[k], exp_pcs[k]);

    // Flush with storage full and an input presented in the same cycle
    drive(1, 32'h00400213, 32'h300, 0, 0);
    drive(1, 32'h00500293, 32'h304, 0, 0);
    drive(1, 32'h00600313, 32'h308, 0, 1); after_edge();
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_ready", in_ready_o, 1'b1);
    leak = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 32'h0, 32'h0, 1, 0);
      #1;
      if (out_valid_o) leak++;
    end
    chk("flush_leak", leak, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++)
      drive($urandom_range(0, 3) != 0, rnd_inst(), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);

    // Asynchronous reset in the middle of a stall
    drive(1, 32'h0070A383, 32'h400, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    #3;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("in_ready_after_mid_rst", in_ready_o, 1'b1);
    for (int k = 0; k < 4; k++) drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
